// File: rtl/ysyx_23060180_pkg.sv
// Shared types and constants for the ysyx_23060180 memory responder.
package ysyx_23060180_pkg;

    localparam logic [31:0] MEM_BASE_DEFAULT = 32'h8000_0000;
    localparam int          WSTRB_W          = 4;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } mem_rsp_t;

endpackage

// File: rtl/ysyx_23060180_mem_pipe.sv
// Delay chain of read responses with synchronous active-low clear.
module ysyx_23060180_mem_pipe
    import ysyx_23060180_pkg::*;
#(
    parameter int STAGES = 1
) (
    input  logic     clk,
    input  logic     clr_n,
    input  mem_rsp_t din,
    output mem_rsp_t dout
);

    mem_rsp_t stage_r [STAGES];

    // Shift responses one stage per cycle; clear drops everything in flight.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[STAGES-1];

endmodule

// File: rtl/ysyx_23060180_mem_resp.sv
// Word-addressed RAM responder: pipelined reads with address error flag,
// byte-strobed writes with a drop pulse for out-of-range writes.
module ysyx_23060180_mem_resp
    import ysyx_23060180_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = MEM_BASE_DEFAULT,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 1
) (
    input  logic               clk,
    input  logic               rstn_in,
    input  logic               mem_rd,
    input  logic [31:0]        mem_raddr,
    output logic [31:0]        mem_rdata,
    output logic               mem_rvalid,
    output logic               mem_err,
    input  logic               mem_wr,
    input  logic [31:0]        mem_waddr,
    input  logic [31:0]        mem_wdata,
    input  logic [WSTRB_W-1:0] mem_wstrb,
    output logic               mem_wdrop
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);

    // The lower-bound test rejects addresses whose offset wrapped on subtraction.
    function automatic logic addr_ok(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - ADDR_BASE;
        return (addr[1:0] == 2'b00) && (addr >= ADDR_BASE) && (off < SPAN);
    endfunction

    logic [31:0]      ram [DEPTH_WORDS];
    logic [31:0]      roff;
    logic [31:0]      woff;
    logic [IDX_W-1:0] ridx;
    logic [IDX_W-1:0] widx;
    logic             rd_ok;
    logic             wr_ok;
    mem_rsp_t         s1_r;
    mem_rsp_t         tail;
    logic             wdrop_r;

    assign roff  = mem_raddr - ADDR_BASE;
    assign woff  = mem_waddr - ADDR_BASE;
    assign ridx  = roff[IDX_W+1:2];
    assign widx  = woff[IDX_W+1:2];
    assign rd_ok = addr_ok(mem_raddr);
    assign wr_ok = addr_ok(mem_waddr);

    // Byte-strobed array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (rstn_in && mem_wr && wr_ok) begin
            for (int b = 0; b < WSTRB_W; b++) begin
                if (mem_wstrb[b]) begin
                    ram[widx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Stage 1: array read (read-first against a same-edge write) or error response.
    always_ff @(posedge clk) begin
        if (!rstn_in) begin
            s1_r <= '0;
        end else begin
            s1_r.valid <= mem_rd;
            s1_r.err   <= mem_rd && !rd_ok;
            if (mem_rd && rd_ok) begin
                s1_r.data <= ram[ridx];
            end else begin
                s1_r.data <= 32'h0;
            end
        end
    end

    // Drop pulse for a write that had strobes set but an illegal address.
    always_ff @(posedge clk) begin
        if (!rstn_in) begin
            wdrop_r <= 1'b0;
        end else begin
            wdrop_r <= mem_wr && (|mem_wstrb) && !wr_ok;
        end
    end

    generate
        if (LATENCY > 1) begin : g_pipe
            ysyx_23060180_mem_pipe #(
                .STAGES (LATENCY - 1)
            ) u_pipe (
                .clk   (clk),
                .clr_n (rstn_in),
                .din   (s1_r),
                .dout  (tail)
            );
        end else begin : g_nopipe
            assign tail = s1_r;
        end
    endgenerate

    assign mem_rvalid = tail.valid;
    assign mem_err    = tail.err;
    assign mem_rdata  = tail.data;
    assign mem_wdrop  = wdrop_r;

endmodule

// File: tb/tb_ysyx_23060180_mem_resp.sv
// Directed bench: three responders (latency 1, 2, 3) share one stimulus stream.
module tb_ysyx_23060180_mem_resp;

    logic        clk = 1'b0;
    logic        rstn_in;
    logic        mem_rd;
    logic [31:0] mem_raddr;
    logic        mem_wr;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    logic [31:0] r1_data, r2_data, r3_data;
    logic        r1_valid, r2_valid, r3_valid;
    logic        r1_err, r2_err, r3_err;
    logic        d1, d2, d3;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ysyx_23060180_mem_resp #(.LATENCY(1)) u1 (
        .clk(clk), .rstn_in(rstn_in), .mem_rd(mem_rd), .mem_raddr(mem_raddr),
        .mem_rdata(r1_data), .mem_rvalid(r1_valid), .mem_err(r1_err),
        .mem_wr(mem_wr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_wdrop(d1));

    ysyx_23060180_mem_resp #(.LATENCY(2)) u2 (
        .clk(clk), .rstn_in(rstn_in), .mem_rd(mem_rd), .mem_raddr(mem_raddr),
        .mem_rdata(r2_data), .mem_rvalid(r2_valid), .mem_err(r2_err),
        .mem_wr(mem_wr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_wdrop(d2));

    ysyx_23060180_mem_resp #(.LATENCY(3)) u3 (
        .clk(clk), .rstn_in(rstn_in), .mem_rd(mem_rd), .mem_raddr(mem_raddr),
        .mem_rdata(r3_data), .mem_rvalid(r3_valid), .mem_err(r3_err),
        .mem_wr(mem_wr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_wdrop(d3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        mem_wr = 1'b1; mem_waddr = a; mem_wdata = d; mem_wstrb = s;
        cycle();
        mem_wr = 1'b0; mem_wstrb = 4'h0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_v1"}, {31'h0, r1_valid}, 32'h0);
        chk({tag, "_v2"}, {31'h0, r2_valid}, 32'h0);
        chk({tag, "_v3"}, {31'h0, r3_valid}, 32'h0);
        chk({tag, "_e3"}, {31'h0, r3_err}, 32'h0);
        chk({tag, "_d2"}, r2_data, 32'h0);
        chk({tag, "_d3"}, r3_data, 32'h0);
        chk({tag, "_wd"}, {31'h0, d1}, 32'h0);
    endtask

    initial begin
        rstn_in = 1'b0; mem_rd = 1'b0; mem_raddr = 32'h0;
        mem_wr = 1'b0; mem_waddr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        @(negedge clk);
        cycle();
        cycle();
        check_all_zero("reset");
        chk("reset_e1", {31'h0, r1_err}, 32'h0);
        chk("reset_d1", r1_data, 32'h0);
        rstn_in = 1'b1;

        // Latency 1 basic read.
        write_word(32'h8000_0000, 32'h0010_0093, 4'hF);
        mem_rd = 1'b1; mem_raddr = 32'h8000_0000;
        cycle();
        mem_rd = 1'b0;
        chk("l1_valid", {31'h0, r1_valid}, 32'h1);
        chk("l1_data", r1_data, 32'h0010_0093);
        chk("l1_err", {31'h0, r1_err}, 32'h0);
        chk("l3_not_yet", {31'h0, r3_valid}, 32'h0);

        // Latency 3 back-to-back reads of words 0..2.
        write_word(32'h8000_0000, 32'h1, 4'hF);
        write_word(32'h8000_0004, 32'h2, 4'hF);
        write_word(32'h8000_0008, 32'h3, 4'hF);
        for (int k = 0; k < 6; k++) begin
            mem_rd    = (k < 3);
            mem_raddr = 32'h8000_0000 + 32'(4 * k);
            cycle();
            chk($sformatf("l3_valid_%0d", k), {31'h0, r3_valid}, (k >= 2 && k <= 4) ? 32'h1 : 32'h0);
            if (k >= 2 && k <= 4) chk($sformatf("l3_data_%0d", k), r3_data, 32'(k - 1));
            chk($sformatf("l1_valid_%0d", k), {31'h0, r1_valid}, (k < 3) ? 32'h1 : 32'h0);
            if (k < 3) chk($sformatf("l1_data_%0d", k), r1_data, 32'(k + 1));
        end

        // Illegal addresses: below base, misaligned, one past the end.
        mem_rd = 1'b1;
        mem_raddr = 32'h7FFF_FFFC; cycle();
        chk("bad_lo_v", {31'h0, r1_valid}, 32'h1);
        chk("bad_lo_e", {31'h0, r1_err}, 32'h1);
        chk("bad_lo_d", r1_data, 32'h0);
        mem_raddr = 32'h8000_0002; cycle();
        chk("bad_mis_e", {31'h0, r1_err}, 32'h1);
        chk("bad_mis_d", r1_data, 32'h0);
        mem_raddr = 32'h8000_4000; cycle();
        chk("bad_hi_e", {31'h0, r1_err}, 32'h1);
        chk("bad_hi_d", r1_data, 32'h0);
        mem_raddr = 32'h8000_3FFC; cycle();
        chk("last_ok_v", {31'h0, r1_valid}, 32'h1);
        chk("last_ok_e", {31'h0, r1_err}, 32'h0);
        mem_rd = 1'b0;

        // Read-first on same-cycle write, then new data.
        write_word(32'h8000_0010, 32'h1122_3344, 4'hF);
        mem_rd = 1'b1; mem_raddr = 32'h8000_0010;
        mem_wr = 1'b1; mem_waddr = 32'h8000_0010; mem_wdata = 32'hAABB_CCDD; mem_wstrb = 4'b0101;
        cycle();
        mem_wr = 1'b0; mem_wstrb = 4'h0;
        chk("rf_old", r1_data, 32'h1122_3344);
        chk("rf_nodrop", {31'h0, d1}, 32'h0);
        cycle();
        mem_rd = 1'b0;
        chk("rf_new", r1_data, 32'h11BB_33DD);

        // Illegal write drops; zero strobe does not.
        write_word(32'h9000_0000, 32'hFFFF_FFFF, 4'hF);
        chk("drop_pulse", {31'h0, d1}, 32'h1);
        cycle();
        chk("drop_end", {31'h0, d1}, 32'h0);
        write_word(32'h9000_0000, 32'hFFFF_FFFF, 4'h0);
        chk("drop_zero_strb", {31'h0, d1}, 32'h0);
        mem_rd = 1'b1; mem_raddr = 32'h8000_0000;
        cycle();
        mem_rd = 1'b0;
        chk("drop_intact", r1_data, 32'h1);

        // Reset with reads in flight; a write during reset is ignored.
        mem_rd = 1'b1; mem_raddr = 32'h8000_0000; cycle();
        mem_raddr = 32'h8000_0004; cycle();
        mem_rd = 1'b0; rstn_in = 1'b0;
        mem_wr = 1'b1; mem_waddr = 32'h8000_0004; mem_wdata = 32'hDEAD_BEEF; mem_wstrb = 4'hF;
        cycle();
        mem_wr = 1'b0; mem_wstrb = 4'h0; rstn_in = 1'b1;
        check_all_zero("rst_mid");
        chk("rst_mid_v1", {31'h0, r1_valid}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk($sformatf("rst_gone2_%0d", k), {31'h0, r2_valid}, 32'h0);
            chk($sformatf("rst_gone3_%0d", k), {31'h0, r3_valid}, 32'h0);
        end
        mem_rd = 1'b1; mem_raddr = 32'h8000_0004;
        cycle();
        mem_rd = 1'b0;
        chk("post_rst_v2", {31'h0, r2_valid}, 32'h0);
        chk("post_rst_d1", r1_data, 32'h2);
        cycle();
        chk("post_rst_l2v", {31'h0, r2_valid}, 32'h1);
        chk("post_rst_l2d", r2_data, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
